dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-port synchronous data memory between the core load/store port (requester 0) and the debug/program-loader port (requester 1). It accepts at most one request per cycle, registers it into a memory-issue stage and returns a response two cycles after acceptance. Conflicts use round-robin fairness. An optional lock lets a requester hold ownership for a bounded burst.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits; must be a multiple of 8
MAX_BURST, 8, maximum consecutive locked grants before forced release; minimum 1

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
req0_valid  in  1  core request valid
req0_ready  out  1  core request accepted this cycle (combinational)
req0_we  in  1  1 = write, 0 = read
req0_lock  in  1  hold ownership after this request
req0_addr  in  ADDR_W  byte address
req0_wdata  in  DATA_W  write data
req0_be  in  DATA_W/8  byte enables
rsp0_valid  out  1  response for requester 0
rsp0_rdata  out  DATA_W  read data; 0 for write responses
req1_*, rsp1_*  same set as requester 0, for the debug/loader port
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, both pipeline stages invalid, FSM=IDLE, last_grant=1 (requester 0 wins the first conflict), burst_cnt=0. Any in-flight response is dropped with no rsp_valid.
- FSM states: IDLE (open arbitration), OWN0 (only requester 0 eligible), OWN1 (only requester 1 eligible).
- IDLE grant rules: only one requester valid → grant it. Both valid → grant the one not equal to last_grant. On grant, last_grant = granted id.
- OWNx grant rules: requester x is granted whenever it is valid. The other requester's ready is held at 0.
- readyX = grant to X. No request is dropped: an unaccepted request must stay valid with stable fields until it is accepted.
- Lock transitions:
  - Accepted request with lock=1 from IDLE → OWNx, burst_cnt=1.
  - In OWNx, an accepted request with lock=0 → IDLE.
  - In OWNx, an accepted lock=1 request increments burst_cnt. When the post-increment value reaches MAX_BURST, the FSM goes to IDLE regardless of lock, so the other requester wins the next conflict.
  - In OWNx, idle cycles (x not valid) keep ownership.
  - burst_cnt resets to 0 on entry to IDLE.
- Stage 1 (issue), cycle N+1 after acceptance at N: registered id, we, addr, wdata and be. mem_en=1 and mem_we=we. When invalid, mem_en=0 and mem_we=0; other mem_* hold their last values.
- Stage 2 (response), cycle N+2: rspX_valid=1 for exactly one cycle, for reads and writes. rdata = mem_rdata for reads, 0 for writes. rsp_valid to the non-matching requester is 0.
- Throughput: one request per cycle, fully pipelined, no memory backpressure. Responses always return in acceptance order, and only one rsp_valid is high in any cycle. Responses cannot be stalled.
- Simultaneous events: a grant at N and a response for an earlier request at N may target the same or different requesters independently.

Test Plan:
- Reset: hold reset=0 for 22 time units with all req_valid toggling → every output stays 0. Release reset → first conflict grants requester 0.
- Single core write: req0 we=1, addr=80, wdata=17, be=4'hF accepted at N → N+1 mem_en=1, mem_we=1, mem_addr=80, mem_wdata=17; N+2 rsp0_valid=1, rsp0_rdata=0.
- Read-back: req0 read addr=80 with memory model returning 17 → rsp0_valid at N+2 with rdata=17. Back-to-back reads at N, N+1, N+2 → three responses at N+2, N+3, N+4.
- Conflict fairness: both requesters continuously valid, no lock, for 6 cycles → grants alternate 0,1,0,1,0,1.
- Locked burst: req1 issues 3 lock=1 requests then 1 lock=0 request while req0 is valid throughout → req0_ready=0 for those 4 cycles, then req0 granted.
- Forced release: MAX_BURST=8, req1 holds lock=1 continuously with req0 valid → after the 8th grant, req0 is granted next. Asserting reset between acceptance and response → no rsp_valid and mem_en=0 immediately.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data memory between core (0) and debug/loader (1) ports.
// Response two cycles after acceptance; ready is combinational, responses cannot be stalled.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_we,
  input  logic                req0_lock,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [DATA_W/8-1:0] req0_be,
  output logic                rsp0_valid,
  output logic [DATA_W-1:0]   rsp0_rdata,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_we,
  input  logic                req1_lock,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [DATA_W/8-1:0] req1_be,
  output logic                rsp1_valid,
  output logic [DATA_W-1:0]   rsp1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  typedef struct packed {
    logic                id;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] be;
  } hdr_t;

  state_t        state;
  logic          last_grant;
  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] burst_nxt;
  logic          gnt0, gnt1;
  logic          acc, acc_lock;
  hdr_t          acc_hdr;
  logic          s1_vld;
  hdr_t          s1;
  logic          s2_vld, s2_id, s2_we;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state)
      OWN0: gnt0 = req0_valid;
      OWN1: gnt1 = req1_valid;
      default: begin
        // last_grant names the previous winner; the other side wins a tie
        if (req0_valid && req1_valid) begin
          gnt0 = last_grant;
          gnt1 = !last_grant;
        end else begin
          gnt0 = req0_valid;
          gnt1 = req1_valid;
        end
      end
    endcase
  end

  assign req0_ready = gnt0 & reset;
  assign req1_ready = gnt1 & reset;
  assign acc        = gnt0 | gnt1;
  assign acc_lock   = gnt1 ? req1_lock : req0_lock;
  assign burst_nxt  = burst_cnt + BW'(1);

  always_comb begin
    acc_hdr = gnt1 ? '{id: 1'b1, we: req1_we, addr: req1_addr, wdata: req1_wdata, be: req1_be}
                   : '{id: 1'b0, we: req0_we, addr: req0_addr, wdata: req0_wdata, be: req0_be};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= '0;
      s1_vld     <= 1'b0;
      s1         <= '0;
      s2_vld     <= 1'b0;
      s2_id      <= 1'b0;
      s2_we      <= 1'b0;
    end else begin
      s1_vld <= acc;
      if (acc) s1 <= acc_hdr;
      s2_vld <= s1_vld;
      s2_id  <= s1.id;
      s2_we  <= s1.we;
      if (acc) begin
        last_grant <= acc_hdr.id;
        if (state == IDLE) begin
          // a one-grant burst limit means a lock can never take effect
          if (acc_lock && MAX_BURST > 1) begin
            state     <= acc_hdr.id ? OWN1 : OWN0;
            burst_cnt <= BW'(1);
          end
        end else if (!acc_lock || burst_nxt == BW'(MAX_BURST)) begin
          state     <= IDLE;
          burst_cnt <= '0;
        end else begin
          burst_cnt <= burst_nxt;
        end
      end
    end
  end

  assign mem_en    = s1_vld;
  assign mem_we    = s1_vld & s1.we;
  assign mem_addr  = s1.addr;
  assign mem_wdata = s1.wdata;
  assign mem_be    = s1.be;

  assign rsp0_valid = s2_vld & ~s2_id;
  assign rsp1_valid = s2_vld & s2_id;
  assign rsp0_rdata = (rsp0_valid && !s2_we) ? mem_rdata : '0;
  assign rsp1_rdata = (rsp1_valid && !s2_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected responses, a monitor pops them.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid, req0_ready, req0_we, req0_lock;
  logic [31:0] req0_addr, req0_wdata;
  logic [3:0]  req0_be;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_lock;
  logic [31:0] req1_addr, req1_wdata;
  logic [3:0]  req1_be;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [0:255] = '{default: '0};

  typedef struct {
    bit          vld;
    bit          we;
    bit          lock;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } rq_t;

  typedef struct {
    bit          id;
    logic [31:0] rdata;
    int          due;
  } ex_t;

  ex_t sb[$];
  ex_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc_cnt = 0;
  int  g;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_be(req0_be),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_be(req1_be),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // synchronous single-port memory, read data one cycle after mem_en
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic any_out();
    return |{req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, mem_be};
  endfunction

  function automatic rq_t rd(input logic [31:0] a, input logic [31:0] e, input bit lk);
    rq_t r;
    r.vld = 1'b1; r.we = 1'b0; r.lock = lk; r.addr = a; r.wdata = '0; r.be = 4'hF; r.exp = e;
    return r;
  endfunction

  function automatic rq_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    rq_t r;
    r.vld = 1'b1; r.we = 1'b1; r.lock = 1'b0; r.addr = a; r.wdata = d; r.be = be; r.exp = '0;
    return r;
  endfunction

  function automatic rq_t nop();
    rq_t r;
    r.vld = 1'b0; r.we = 1'b0; r.lock = 1'b0; r.addr = '0; r.wdata = '0; r.be = '0; r.exp = '0;
    return r;
  endfunction

  task automatic set_in(input rq_t r0, input rq_t r1);
    req0_valid = r0.vld; req0_we = r0.we; req0_lock = r0.lock;
    req0_addr = r0.addr; req0_wdata = r0.wdata; req0_be = r0.be;
    req1_valid = r1.vld; req1_we = r1.we; req1_lock = r1.lock;
    req1_addr = r1.addr; req1_wdata = r1.wdata; req1_be = r1.be;
  endtask

  // one cycle: drive, observe grant at negedge, queue expected response; g=2 none, 3 both
  task automatic cyc(input rq_t r0, input rq_t r1, output int gr);
    set_in(r0, r1);
    @(negedge clk);
    gr = 2;
    if (req0_valid && req0_ready) begin
      gr = 0;
      sb.push_back('{id: 1'b0, rdata: r0.exp, due: cyc_cnt + 2});
    end
    if (req1_valid && req1_ready) begin
      gr = (gr == 0) ? 3 : 1;
      sb.push_back('{id: 1'b1, rdata: r1.exp, due: cyc_cnt + 2});
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rsp0_valid || rsp1_valid) begin
      chk("rsp_onehot", rsp0_valid & rsp1_valid, 0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got rsp0_valid=%0b rsp1_valid=%0b, expected none (t=%0t)",
                 rsp0_valid, rsp1_valid, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", rsp1_valid, mon_e.id);
        chk("rsp_rdata", rsp1_valid ? rsp1_rdata : rsp0_rdata, mon_e.rdata);
        chk("rsp_cycle", cyc_cnt, mon_e.due);
      end
    end
  end

  initial begin
    set_in(nop(), nop());
    // reset held with requests toggling: every output must stay low
    for (int i = 0; i < 11; i++) begin
      req0_valid = i[0];
      req1_valid = i[1];
      #1;
      chk("rst_outs", any_out(), 0);
      #1;
    end
    set_in(nop(), nop());
    reset = 1'b1;
    @(posedge clk);
    #1;

    cyc(rd(0, 0, 0), rd(4, 0, 0), g);              chk("first_conflict", g, 0);
    cyc(nop(), rd(4, 0, 0), g);                     chk("r1_after", g, 1);

    cyc(wr(80, 17, 4'hF), nop(), g);                chk("wr_grant", g, 0);
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 80);
    chk("wr_mem_wdata", mem_wdata, 17);
    chk("wr_mem_be", mem_be, 4'hF);
    cyc(wr(84, 32'hAABBCCDD, 4'h3), nop(), g);      chk("wr_be_grant", g, 0);
    cyc(nop(), nop(), g);
    chk("idle_mem_en", mem_en, 0);
    chk("idle_mem_we", mem_we, 0);

    cyc(rd(80, 17, 0), nop(), g);                   chk("rd_grant", g, 0);
    chk("rd_mem_we", mem_we, 0);
    cyc(rd(84, 32'h0000CCDD, 0), nop(), g);         chk("b2b_grant0", g, 0);
    cyc(rd(80, 17, 0), nop(), g);                   chk("b2b_grant1", g, 0);

    cyc(nop(), wr(100, 32'h55, 4'hF), g);           chk("r1_wr_grant", g, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(rd(80, 17, 0), rd(80, 17, 0), g);         chk("fair_grant", g, i % 2);
    end

    cyc(rd(100, 32'h55, 0), nop(), g);              chk("pre_lock", g, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(rd(100, 32'h55, 0), rd(100, 32'h55, 1), g); chk("lock_grant", g, 1);
    end
    cyc(rd(100, 32'h55, 0), rd(100, 32'h55, 0), g); chk("unlock_grant", g, 1);
    cyc(rd(100, 32'h55, 0), rd(100, 32'h55, 0), g); chk("after_unlock", g, 0);
    cyc(nop(), rd(100, 32'h55, 0), g);              chk("r1_next", g, 1);

    cyc(rd(80, 17, 0), nop(), g);                   chk("pre_burst", g, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(rd(80, 17, 0), rd(100, 32'h55, 1), g);    chk("burst_grant", g, 1);
    end
    cyc(rd(80, 17, 0), nop(), g);                   chk("own_idle_hold", g, 2);
    for (int i = 0; i < 4; i++) begin
      cyc(rd(80, 17, 0), rd(100, 32'h55, 1), g);    chk("burst_grant", g, 1);
    end
    cyc(rd(80, 17, 0), rd(100, 32'h55, 1), g);      chk("forced_release", g, 0);
    cyc(nop(), nop(), g);

    // reset between acceptance and response drops the in-flight read
    cyc(rd(80, 17, 0), nop(), g);                   chk("inflight_grant", g, 0);
    chk("inflight_mem_en", mem_en, 1);
    set_in(nop(), nop());
    reset = 1'b0;
    sb.delete();
    #1;
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_outs", any_out(), 0);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(rd(80, 17, 0), rd(4, 0, 0), g);             chk("post_rst_conflict", g, 0);
    cyc(nop(), rd(4, 0, 0), g);                     chk("post_rst_r1", g, 1);
    repeat (4) cyc(nop(), nop(), g);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
